// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU word, pipe-state command and fetch FSM encodings.
// Revision 1.0
`default_nettype none
package cpu_types_pkg;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        PIPE_ENABLE = 2'd0,
        PIPE_STALL  = 2'd1,
        PIPE_NOP    = 2'd2
    } pipe_state_t;

    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t FETCH  = 2'd0;
    localparam fetch_state_t HOLD   = 2'd1;
    localparam fetch_state_t HALTED = 2'd2;

    localparam word_t NOP_INSTR = 32'h0;
endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-cache request/response bus between fetch and icache.
// Revision 1.0
`default_nettype none
interface fetch_stage_if;
    import cpu_types_pkg::*;
    logic  iREN;
    word_t iaddr;
    logic  ihit;
    word_t iload;

    modport master (output iREN, output iaddr, input ihit, input iload);
    modport slave  (input iREN, input iaddr, output ihit, output iload);
endinterface
`default_nettype wire

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB, combinational lookup, clocked update.
// Revision 1.0
`default_nettype none
module branch_target_buffer
    import cpu_types_pkg::*;
#(
    parameter int BTB_ENTRIES = 16
) (
    input  wire logic  CLK,
    input  wire logic  nRST,
    input  wire word_t lookup_pc,
    output logic       hit,
    output word_t      target,
    input  wire logic  update,
    input  wire word_t update_pc,
    input  wire word_t update_target
);
    localparam int IDXW = $clog2(BTB_ENTRIES);
    localparam int TAGW = 30 - IDXW;

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAGW-1:0]        tag_q    [BTB_ENTRIES];
    word_t                  target_q [BTB_ENTRIES];

    logic [IDXW-1:0] rd_idx, wr_idx;
    logic [TAGW-1:0] rd_tag, wr_tag;

    assign rd_idx = lookup_pc[IDXW+1:2];
    assign rd_tag = lookup_pc[31:IDXW+2];
    assign wr_idx = update_pc[IDXW+1:2];
    assign wr_tag = update_pc[31:IDXW+2];

    // Reads see pre-edge contents, so a same-cycle write returns the old entry.
    assign hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign target = target_q[rd_idx];

    wire logic unused_lookup_lsb = ^{lookup_pc[1:0], update_pc[1:0]};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= '0;
        end else if (update) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (update) begin
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= update_target;
        end
    end
endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, icache handshake and fetch/decode latch; optional BTB under FETCH_BTB_EN.
// Revision 1.0
`default_nettype none
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_RESET    = 32'h0,
    parameter int    BTB_ENTRIES = 16
) (
    input  wire logic        CLK,
    input  wire logic        nRST,
    input  pipe_state_t      fd_state,
    fetch_stage_if.master    ibus,
    input  wire logic        redirect_en,
    input  wire word_t       redirect_pc,
    input  wire logic        halt,
    input  wire logic        bt_update,
    input  wire word_t       bt_pc,
    input  wire word_t       bt_target,
    output word_t            d_instr,
    output word_t            d_pc4,
    output logic             d_pred_taken
);
    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        buf_q, buf_d;
    word_t        instr_q, instr_d;
    word_t        pc4_q, pc4_d;
    logic         pred_q, pred_d;

    logic  btb_hit;
    word_t btb_target;
    word_t pc_plus4;
    word_t next_pc;

`ifdef FETCH_BTB_EN
    branch_target_buffer #(
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .CLK           (CLK),
        .nRST          (nRST),
        .lookup_pc     (pc_q),
        .hit           (btb_hit),
        .target        (btb_target),
        .update        (bt_update),
        .update_pc     (bt_pc),
        .update_target (bt_target)
    );
`else
    assign btb_hit    = 1'b0;
    assign btb_target = '0;
    wire logic unused_bt = ^{bt_update, bt_pc, bt_target};
`endif

    assign pc_plus4 = pc_q + 32'd4;
    assign next_pc  = btb_hit ? btb_target : pc_plus4;

    assign ibus.iREN    = (state_q == FETCH);
    assign ibus.iaddr   = pc_q;
    assign d_instr      = instr_q;
    assign d_pc4        = pc4_q;
    assign d_pred_taken = pred_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        buf_d   = buf_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        pred_d  = pred_q;

        if (halt) begin
            instr_d = NOP_INSTR;
            pc4_d   = '0;
            pred_d  = 1'b0;
            state_d = HALTED;
        end else if (state_q == HALTED) begin
            state_d = HALTED;
        end else if (redirect_en) begin
            // Any instruction arriving this cycle belongs to the wrong path.
            pc_d    = redirect_pc;
            buf_d   = NOP_INSTR;
            instr_d = NOP_INSTR;
            pc4_d   = '0;
            pred_d  = 1'b0;
            state_d = FETCH;
        end else begin
            case (fd_state)
                PIPE_NOP: begin
                    instr_d = NOP_INSTR;
                    pc4_d   = '0;
                    pred_d  = 1'b0;
                end
                PIPE_STALL: begin
                    if (state_q == FETCH && ibus.ihit) begin
                        buf_d   = ibus.iload;
                        state_d = HOLD;
                    end
                end
                PIPE_ENABLE: begin
                    if (state_q == HOLD) begin
                        instr_d = buf_q;
                        pc4_d   = pc_plus4;
                        pred_d  = btb_hit;
                        pc_d    = next_pc;
                        state_d = FETCH;
                    end else if (ibus.ihit) begin
                        instr_d = ibus.iload;
                        pc4_d   = pc_plus4;
                        pred_d  = btb_hit;
                        pc_d    = next_pc;
                    end else begin
                        instr_d = NOP_INSTR;
                        pc4_d   = '0;
                        pred_d  = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= FETCH;
            pc_q    <= PC_RESET;
            buf_q   <= NOP_INSTR;
            instr_q <= NOP_INSTR;
            pc4_q   <= '0;
            pred_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            pred_q  <= pred_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps
module tb_fetch_stage;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    pipe_state_t fd_state;
    logic        redirect_en, halt, bt_update, d_pred_taken;
    word_t       redirect_pc, bt_pc, bt_target, d_instr, d_pc4;
    int          checks = 0;
    int          errors = 0;

`ifdef FETCH_BTB_EN
    localparam word_t      EXP_BTB_NEXT = 32'h80;
    localparam logic [31:0] EXP_PRED    = 32'd1;
`else
    localparam word_t      EXP_BTB_NEXT = 32'h24;
    localparam logic [31:0] EXP_PRED    = 32'd0;
`endif

    fetch_stage_if ibus ();

    fetch_stage #(.PC_RESET(32'h0), .BTB_ENTRIES(16)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .fd_state     (fd_state),
        .ibus         (ibus.master),
        .redirect_en  (redirect_en),
        .redirect_pc  (redirect_pc),
        .halt         (halt),
        .bt_update    (bt_update),
        .bt_pc        (bt_pc),
        .bt_target    (bt_target),
        .d_instr      (d_instr),
        .d_pc4        (d_pc4),
        .d_pred_taken (d_pred_taken)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b0; fd_state = PIPE_ENABLE; redirect_en = 1'b0; redirect_pc = '0;
        halt = 1'b0; bt_update = 1'b0; bt_pc = '0; bt_target = '0;
        ibus.ihit = 1'b0; ibus.iload = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_instr", d_instr, 32'h0);
        chk("rst_pc4", d_pc4, 32'h0);
        chk("rst_pred", {31'b0, d_pred_taken}, 32'h0);
        chk("rst_iaddr", ibus.iaddr, 32'h0);
        chk("rst_iren", {31'b0, ibus.iREN}, 32'h1);
        @(negedge CLK);
        nRST = 1'b1;
        #1;

        // Back-to-back hits
        for (int i = 0; i < 4; i++) begin
            ibus.ihit = 1'b1; ibus.iload = 32'h1000 + i;
            step();
            chk("b2b_instr", d_instr, 32'h1000 + i);
            chk("b2b_pc4", d_pc4, 32'd4 * (i + 1));
            chk("b2b_iaddr", ibus.iaddr, 32'd4 * (i + 1));
        end

        // Hit every third cycle, starting from pc=16
        for (int i = 0; i < 6; i++) begin
            ibus.ihit  = (i % 3 == 2);
            ibus.iload = 32'h2000 + i;
            step();
            if (i % 3 == 2) begin
                chk("sparse_instr", d_instr, 32'h2000 + i);
                chk("sparse_iaddr", ibus.iaddr, (i == 2) ? 32'd20 : 32'd24);
            end else begin
                chk("sparse_bubble", d_instr, 32'h0);
                chk("sparse_hold", ibus.iaddr, (i < 2) ? 32'd16 : 32'd20);
            end
        end

        // Move to 0x40, then stall-hit and hold
        ibus.ihit = 1'b0; redirect_en = 1'b1; redirect_pc = 32'h40;
        step();
        redirect_en = 1'b0;
        chk("redir40_iaddr", ibus.iaddr, 32'h40);
        fd_state = PIPE_STALL; ibus.ihit = 1'b1; ibus.iload = 32'hABCD;
        step();
        chk("stall_iren", {31'b0, ibus.iREN}, 32'h0);
        chk("stall_instr", d_instr, 32'h0);
        ibus.iload = 32'hBAD0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("held_iren", {31'b0, ibus.iREN}, 32'h0);
            chk("held_iaddr", ibus.iaddr, 32'h40);
        end
        fd_state = PIPE_ENABLE; ibus.ihit = 1'b0;
        step();
        chk("release_instr", d_instr, 32'hABCD);
        chk("release_pc4", d_pc4, 32'h44);
        chk("release_iaddr", ibus.iaddr, 32'h44);
        chk("release_iren", {31'b0, ibus.iREN}, 32'h1);
        step();
        chk("no_dup", d_instr, 32'h0);

        // NOP command flushes the latch but leaves pc alone
        ibus.ihit = 1'b1; ibus.iload = 32'h5555;
        step();
        chk("pre_nop_instr", d_instr, 32'h5555);
        fd_state = PIPE_NOP; ibus.iload = 32'h6666;
        step();
        chk("nop_instr", d_instr, 32'h0);
        chk("nop_iaddr", ibus.iaddr, 32'h48);

        // Redirect wins over a same-cycle hit
        fd_state = PIPE_ENABLE; ibus.iload = 32'hDEAD; redirect_en = 1'b1; redirect_pc = 32'h100;
        step();
        redirect_en = 1'b0; ibus.ihit = 1'b0;
        chk("redir_instr", d_instr, 32'h0);
        chk("redir_iaddr", ibus.iaddr, 32'h100);

        // Wrap-around of pc+4
        redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_en = 1'b0; ibus.ihit = 1'b1; ibus.iload = 32'h1234;
        step();
        ibus.ihit = 1'b0;
        chk("wrap_pc4", d_pc4, 32'h0);
        chk("wrap_iaddr", ibus.iaddr, 32'h0);

        // BTB train then fetch the trained PC
        fd_state = PIPE_STALL; bt_update = 1'b1; bt_pc = 32'h20; bt_target = 32'h80;
        step();
        bt_update = 1'b0; fd_state = PIPE_ENABLE; redirect_en = 1'b1; redirect_pc = 32'h20;
        step();
        redirect_en = 1'b0; ibus.ihit = 1'b1; ibus.iload = 32'h7777;
        step();
        chk("btb_instr", d_instr, 32'h7777);
        chk("btb_pc4", d_pc4, 32'h24);
        chk("btb_pred", {31'b0, d_pred_taken}, EXP_PRED);
        chk("btb_iaddr", ibus.iaddr, EXP_BTB_NEXT);

        // Halt while holding, with redirect also asserted
        fd_state = PIPE_STALL; ibus.iload = 32'hAAAA;
        step();
        chk("hold_iren", {31'b0, ibus.iREN}, 32'h0);
        halt = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h200;
        step();
        halt = 1'b0;
        chk("halt_iren", {31'b0, ibus.iREN}, 32'h0);
        chk("halt_instr", d_instr, 32'h0);
        fd_state = PIPE_ENABLE;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("halted_iren", {31'b0, ibus.iREN}, 32'h0);
            chk("halted_instr", d_instr, 32'h0);
            chk("halted_iaddr", ibus.iaddr, EXP_BTB_NEXT);
        end
        redirect_en = 1'b0;

        // Asynchronous reset mid-cycle
        #2 nRST = 1'b0;
        #1;
        chk("arst_iaddr", ibus.iaddr, 32'h0);
        chk("arst_iren", {31'b0, ibus.iREN}, 32'h1);
        chk("arst_instr", d_instr, 32'h0);
        @(negedge CLK);
        nRST = 1'b1; ibus.ihit = 1'b1; ibus.iload = 32'h9999;
        step();
        chk("resume_instr", d_instr, 32'h9999);
        chk("resume_pc4", d_pc4, 32'h4);
        chk("resume_pred", {31'b0, d_pred_taken}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
